// File: rtl/instr_fsm.sv
// Moore sequencer for the register file / ALU datapath: launches one instruction
// per start pulse, steps through its micro-operations, then returns to WAIT.
module instr_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel
);

  typedef enum logic [3:0] {
    S_WAIT      = 4'd0,
    S_DECODE    = 4'd1,
    S_GET_A     = 4'd2,
    S_GET_B     = 4'd3,
    S_ALU       = 4'd4,
    S_ALU_S     = 4'd5,
    S_WRITE_REG = 4'd6,
    S_WRITE_IMM = 4'd7
  } state_t;

  localparam logic [4:0] I_MOV_REG = 5'b110_00;
  localparam logic [4:0] I_MOV_IMM = 5'b110_10;
  localparam logic [4:0] I_ADD     = 5'b101_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [4:0] I_AND     = 5'b101_10;
  localparam logic [4:0] I_MVN     = 5'b101_11;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_RN   = 3'b001;
  localparam logic [2:0] SEL_RD   = 3'b010;
  localparam logic [2:0] SEL_RM   = 3'b100;

  state_t     state_q, state_d;
  logic [2:0] opcode_q, opcode_d;
  logic [1:0] op_q, op_d;
  logic       w_q, w_d;
  logic [2:0] nsel_q, nsel_d;
  logic       vsel_q, vsel_d;
  logic       write_q, write_d;
  logic       loada_q, loada_d;
  logic       loadb_q, loadb_d;
  logic       loadc_q, loadc_d;
  logic       loads_q, loads_d;
  logic       asel_q, asel_d;

  logic [4:0] instr_q;
  assign instr_q = {opcode_q, op_q};

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op_d     = op_q;

    unique case (state_q)
      S_WAIT: begin
        if (s) begin
          opcode_d = opcode;
          op_d     = op;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (instr_q)
          I_MOV_IMM:             state_d = S_WRITE_IMM;
          I_MOV_REG, I_MVN:      state_d = S_GET_B;
          I_ADD, I_AND, I_CMP:   state_d = S_GET_A;
          default:               state_d = S_WAIT;
        endcase
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = (instr_q == I_CMP) ? S_ALU_S : S_ALU;
      S_ALU:       state_d = S_WRITE_REG;
      S_ALU_S:     state_d = S_WAIT;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase

    // Outputs are computed for the state being entered so they register in step with it.
    w_d     = 1'b0;
    nsel_d  = SEL_NONE;
    vsel_d  = 1'b0;
    write_d = 1'b0;
    loada_d = 1'b0;
    loadb_d = 1'b0;
    loadc_d = 1'b0;
    loads_d = 1'b0;
    asel_d  = 1'b0;

    unique case (state_d)
      S_WAIT:   w_d = 1'b1;
      S_GET_A: begin
        nsel_d  = SEL_RN;
        loada_d = 1'b1;
      end
      S_GET_B: begin
        nsel_d  = SEL_RM;
        loadb_d = 1'b1;
      end
      S_ALU: begin
        loadc_d = 1'b1;
        asel_d  = ({opcode_d, op_d} == I_MOV_REG);
      end
      S_ALU_S:  loads_d = 1'b1;
      S_WRITE_REG: begin
        nsel_d  = SEL_RD;
        write_d = 1'b1;
      end
      S_WRITE_IMM: begin
        nsel_d  = SEL_RN;
        vsel_d  = 1'b1;
        write_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_WAIT;
      opcode_q <= 3'b000;
      op_q     <= 2'b00;
      w_q      <= 1'b1;
      nsel_q   <= SEL_NONE;
      vsel_q   <= 1'b0;
      write_q  <= 1'b0;
      loada_q  <= 1'b0;
      loadb_q  <= 1'b0;
      loadc_q  <= 1'b0;
      loads_q  <= 1'b0;
      asel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_q     <= op_d;
      w_q      <= w_d;
      nsel_q   <= nsel_d;
      vsel_q   <= vsel_d;
      write_q  <= write_d;
      loada_q  <= loada_d;
      loadb_q  <= loadb_d;
      loadc_q  <= loadc_d;
      loads_q  <= loads_d;
      asel_q   <= asel_d;
    end
  end

  assign w     = w_q;
  assign nsel  = nsel_q;
  assign vsel  = vsel_q;
  assign write = write_q;
  assign loada = loada_q;
  assign loadb = loadb_q;
  assign loadc = loadc_q;
  assign loads = loads_q;
  assign asel  = asel_q;

endmodule

// File: tb/tb_instr_fsm.sv
// Directed bench for instr_fsm: checks the registered strobe pattern of every
// instruction class, cycle counts, s handling and reset in mid-sequence.
module tb_instr_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic       w, vsel, write, loada, loadb, loadc, loads, asel;
  logic [2:0] nsel;

  int checks = 0;
  int failures = 0;

  instr_fsm dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel)
  );

  always #5 clk = ~clk;

  // Packed view: {w, nsel[2:0], vsel, write, loada, loadb, loadc, loads, asel}
  logic [10:0] outs;
  assign outs = {w, nsel, vsel, write, loada, loadb, loadc, loads, asel};

  localparam logic [10:0] E_WAIT    = 11'b1_000_0_0_0000_0;
  localparam logic [10:0] E_DEC     = 11'b0_000_0_0_0000_0;
  localparam logic [10:0] E_GA      = 11'b0_001_0_0_1000_0;
  localparam logic [10:0] E_GB      = 11'b0_100_0_0_0100_0;
  localparam logic [10:0] E_ALU     = 11'b0_000_0_0_0010_0;
  localparam logic [10:0] E_ALU_MOV = 11'b0_000_0_0_0010_1;
  localparam logic [10:0] E_ALUS    = 11'b0_000_0_0_0001_0;
  localparam logic [10:0] E_WREG    = 11'b0_010_0_1_0000_0;
  localparam logic [10:0] E_WIMM    = 11'b0_001_1_1_0000_0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs !== E_WAIT) begin
        failures++;
        $display("[TB] FAIL reset_hold cycle %0d: got %b expected %b", i, outs, E_WAIT);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (outs !== E_WAIT) begin
        failures++;
        $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", i, outs, E_WAIT);
      end
    end
  endtask

  task automatic test_mov_imm();
    logic [10:0] exp [3] = '{E_DEC, E_WIMM, E_WAIT};
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      s = 1'b0;
      checks++;
      if (outs !== exp[i]) begin
        failures++;
        $display("[TB] FAIL mov_imm step %0d: got %b expected %b", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_add();
    logic [10:0] exp [5] = '{E_DEC, E_GA, E_GB, E_ALU, E_WREG};
    int busy = 0;
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    tick();
    s = 1'b0;
    while (outs[10] !== 1'b1 && busy < 20) begin
      checks++;
      if (busy < 5 && outs !== exp[busy]) begin
        failures++;
        $display("[TB] FAIL add step %0d: got %b expected %b", busy, outs, exp[busy]);
      end
      busy++;
      tick();
    end
    checks++;
    if (busy !== 5) begin
      failures++;
      $display("[TB] FAIL add_busy_cycles: got %0d expected 5", busy);
    end
    checks++;
    if (outs !== E_WAIT) begin
      failures++;
      $display("[TB] FAIL add_return: got %b expected %b", outs, E_WAIT);
    end
  endtask

  task automatic test_cmp();
    logic [10:0] exp [5] = '{E_DEC, E_GA, E_GB, E_ALUS, E_WAIT};
    int writes = 0;
    opcode = 3'b101; op = 2'b01; s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      s = 1'b0;
      if (write === 1'b1) writes++;
      checks++;
      if (outs !== exp[i]) begin
        failures++;
        $display("[TB] FAIL cmp step %0d: got %b expected %b", i, outs, exp[i]);
      end
    end
    checks++;
    if (writes !== 0) begin
      failures++;
      $display("[TB] FAIL cmp_no_write: got %0d write cycles expected 0", writes);
    end
  endtask

  task automatic test_mov_reg_mvn_and();
    logic [10:0] exp_mov [5] = '{E_DEC, E_GB, E_ALU_MOV, E_WREG, E_WAIT};
    logic [10:0] exp_mvn [5] = '{E_DEC, E_GB, E_ALU, E_WREG, E_WAIT};
    logic [10:0] exp_and [6] = '{E_DEC, E_GA, E_GB, E_ALU, E_WREG, E_WAIT};
    opcode = 3'b110; op = 2'b00; s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      s = 1'b0;
      checks++;
      if (outs !== exp_mov[i]) begin
        failures++;
        $display("[TB] FAIL mov_reg step %0d: got %b expected %b", i, outs, exp_mov[i]);
      end
    end
    opcode = 3'b101; op = 2'b11; s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      s = 1'b0;
      checks++;
      if (outs !== exp_mvn[i]) begin
        failures++;
        $display("[TB] FAIL mvn step %0d: got %b expected %b", i, outs, exp_mvn[i]);
      end
    end
    opcode = 3'b101; op = 2'b10; s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      s = 1'b0;
      checks++;
      if (outs !== exp_and[i]) begin
        failures++;
        $display("[TB] FAIL and step %0d: got %b expected %b", i, outs, exp_and[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [2:0] opc [3] = '{3'b011, 3'b110, 3'b000};
    logic [1:0] ops [3] = '{2'b00, 2'b01, 2'b10};
    for (int k = 0; k < 3; k++) begin
      opcode = opc[k]; op = ops[k]; s = 1'b1;
      tick();
      s = 1'b0;
      checks++;
      if (outs !== E_DEC) begin
        failures++;
        $display("[TB] FAIL invalid_decode %0d: got %b expected %b", k, outs, E_DEC);
      end
      tick();
      checks++;
      if (outs !== E_WAIT) begin
        failures++;
        $display("[TB] FAIL invalid_return %0d: got %b expected %b", k, outs, E_WAIT);
      end
    end
  endtask

  task automatic test_s_ignored();
    // ADD with s toggling and opcode/op scrambled while busy
    logic [10:0] exp [6] = '{E_DEC, E_GA, E_GB, E_ALU, E_WREG, E_WAIT};
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      s = (i % 2 == 1) || (i == 4);
      if (i == 5) s = 1'b0;
      opcode = 3'b110; op = 2'b10;
      checks++;
      if (outs !== exp[i]) begin
        failures++;
        $display("[TB] FAIL s_ignored step %0d: got %b expected %b", i, outs, exp[i]);
      end
    end
    tick();
    checks++;
    if (outs !== E_WAIT) begin
      failures++;
      $display("[TB] FAIL s_ignored_idle: got %b expected %b", outs, E_WAIT);
    end
  endtask

  task automatic test_back_to_back();
    // s held high relaunches on the first edge back in WAIT
    logic [10:0] exp [5] = '{E_DEC, E_WIMM, E_WAIT, E_DEC, E_WIMM};
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) s = 1'b0;
      checks++;
      if (outs !== exp[i]) begin
        failures++;
        $display("[TB] FAIL back_to_back step %0d: got %b expected %b", i, outs, exp[i]);
      end
    end
    tick();
    checks++;
    if (outs !== E_WAIT) begin
      failures++;
      $display("[TB] FAIL back_to_back_end: got %b expected %b", outs, E_WAIT);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] exp [5] = '{E_DEC, E_GA, E_GB, E_ALU, E_WREG};
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      s = 1'b0;
      checks++;
      if (outs !== exp[i]) begin
        failures++;
        $display("[TB] FAIL reset_mid step %0d: got %b expected %b", i, outs, exp[i]);
      end
    end
    reset = 1'b1; s = 1'b1; opcode = 3'b110; op = 2'b10;
    @(negedge clk);
    checks++;
    if (write !== 1'b1 || nsel !== 3'b010 || vsel !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_write: got write=%b nsel=%b vsel=%b expected 1 010 0", write, nsel, vsel);
    end
    tick();
    checks++;
    if (outs !== E_WAIT) begin
      failures++;
      $display("[TB] FAIL reset_mid_wait: got %b expected %b", outs, E_WAIT);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (outs !== E_DEC) begin
      failures++;
      $display("[TB] FAIL reset_mid_relaunch: got %b expected %b", outs, E_DEC);
    end
    tick();
    s = 1'b0;
    checks++;
    if (outs !== E_WIMM) begin
      failures++;
      $display("[TB] FAIL reset_mid_wimm: got %b expected %b", outs, E_WIMM);
    end
    tick();
    checks++;
    if (outs !== E_WAIT) begin
      failures++;
      $display("[TB] FAIL reset_mid_end: got %b expected %b", outs, E_WAIT);
    end
    // Reset from GET_A returns straight to WAIT
    opcode = 3'b101; op = 2'b01; s = 1'b1;
    tick();
    s = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (outs !== E_WAIT) begin
      failures++;
      $display("[TB] FAIL reset_from_geta: got %b expected %b", outs, E_WAIT);
    end
    tick();
    checks++;
    if (outs !== E_WAIT) begin
      failures++;
      $display("[TB] FAIL reset_from_geta_idle: got %b expected %b", outs, E_WAIT);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mov_reg_mvn_and();
    test_invalid();
    test_s_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/instr_fsm.md
Name: instr_fsm

Overview:
- Moore controller that sequences the 8x16 register file and its surrounding datapath (A/B operand registers, ALU, C result register, status register) for one instruction at a time.
- Sits between the instruction register/decoder and the datapath.
- Accepts a start pulse with opcode/op fields, drives register-select, load and write strobes for each micro-step, then returns to a waiting state.

Parameters:
none

Ports:
clk  in  1  clock; state register updates on rising edge
reset  in  1  synchronous, active-high reset
s  in  1  start request, sampled only in WAIT
opcode  in  3  instruction class (110 move, 101 ALU)
op  in  2  sub-operation
w  out  1  1 = idle in WAIT, ready for s
nsel  out  3  one-hot register-field select: [0]=Rn, [1]=Rd, [2]=Rm; 000 = none
vsel  out  1  regfile write data select: 0 = C result, 1 = sign-extended imm8
write  out  1  regfile write enable
loada  out  1  load A operand register
loadb  out  1  load B operand register
loadc  out  1  load C result register
loads  out  1  load status flags
asel  out  1  1 = ALU A input forced to 0

Behaviour:
- Reset, taking effect at the rising edge where reset=1: state=WAIT, latched opcode/op=0, w=1, all other outputs 0.
- Outputs are a pure function of the current state and the latched op. No output depends combinationally on s/opcode/op inputs.
- In WAIT with s=1 at a rising edge:
  - Latch opcode and op.
  - Go to DECODE.
- s is ignored in every other state. s held high re-launches at the first edge back in WAIT.
- Decoded instructions and state sequences (all return to WAIT):
  - MOV Rn,#imm8 (110,10): DECODE -> WRITE_IMM.
  - MOV Rd,Rm (110,00): DECODE -> GET_B -> ALU -> WRITE_REG.
  - ADD (101,00) and AND (101,10): DECODE -> GET_A -> GET_B -> ALU -> WRITE_REG.
  - CMP (101,01): DECODE -> GET_A -> GET_B -> ALU_S.
  - MVN (101,11): DECODE -> GET_B -> ALU -> WRITE_REG.
  - Any other opcode/op: DECODE -> WAIT. No strobes asserted.
- Per-state outputs (unlisted outputs = 0):
  - WAIT: w=1.
  - DECODE: none.
  - GET_A: nsel=001, loada=1.
  - GET_B: nsel=100, loadb=1.
  - ALU: loadc=1; asel=1 only for MOV Rd,Rm.
  - ALU_S: loads=1.
  - WRITE_REG: nsel=010, vsel=0, write=1.
  - WRITE_IMM: nsel=001, vsel=1, write=1.
- Timing against the regfile:
  - The regfile writes on the falling edge. write/nsel/vsel are stable for the whole state cycle, so the write lands mid-cycle of WRITE_*.
  - Reads are combinational. Operand registers capture at the rising edge ending GET_A/GET_B.
- Busy cycles (w=0) per instruction: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD/AND 5, invalid 1.
- Exactly one write pulse per writing instruction. Never write and loadc in the same state.
- Reset mid-operation:
  - The current state's outputs persist until the rising edge. A WRITE_* state with reset asserted still completes its falling-edge write.
  - The next state is WAIT with no further strobes.
- Unreachable state encodings go to WAIT on the next edge.

Test Plan:
1. Reset 2 cycles, s=0 -> w=1, nsel=000, write=0, all loads 0 for 5 idle cycles.
2. s=1, opcode=110, op=10 for one cycle:
   - Next cycles: DECODE (all 0), then WRITE_IMM (nsel=001, vsel=1, write=1).
   - w=1 again on the 3rd cycle. With datapath attached, imm8=0x2A lands in R[Rn].
3. ADD with R1=5, R2=7, Rn=1, Rm=2, Rd=3:
   - Strobe order: loada (nsel=001), loadb (nsel=100), loadc, then write (nsel=010, vsel=0).
   - w low exactly 5 cycles; R3=12.
4. CMP with equal operands:
   - loads pulses once in the 4th busy cycle; write never asserted; regfile unchanged.
   - MOV Rd,Rm shows asel=1 only in the ALU cycle.
5. Invalid opcode=011:
   - One DECODE cycle with no strobes, then WAIT.
   - s toggled during a busy ADD has no effect on the sequence or cycle count.
6. Reset asserted during WRITE_REG:
   - The write completes at that cycle's falling edge.
   - Next edge gives w=1 and no strobes; s held high thereafter starts the next instruction on the first WAIT edge.
